// File: rtl/exec_wb_pipe.sv
// Two-stage execute / write-back datapath with register file, flags and store backpressure.
// Optional macro EXEC_FWD_EN enables the W-to-E bypass; otherwise RAW hazards stall one cycle.
module exec_wb_pipe #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int MEM_AW   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   alu_opcode,
  input  logic [$clog2(NUM_REGS)-1:0]  raddr1,
  input  logic [$clog2(NUM_REGS)-1:0]  raddr2,
  input  logic                         op2_imm_sel,
  input  logic [DATA_W-1:0]            op2_imm,
  input  logic                         op2_mem_sel,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         update_flags,
  input  logic                         reg_wen,
  input  logic [$clog2(NUM_REGS)-1:0]  reg_waddr,
  input  logic                         st_en,
  input  logic [MEM_AW-1:0]            st_addr,
  input  logic [1:0]                   wb_mode,
  output logic                         mem_we,
  output logic [MEM_AW-1:0]            mem_waddr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  output logic                         eq_flag,
  output logic                         carry,
  output logic                         zero,
  output logic                         neg
);
  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  logic              w_valid_q,     w_valid_d;
  logic [DATA_W-1:0] result_w_q,    result_w_d;
  logic [1:0]        wb_mode_w_q,   wb_mode_w_d;
  logic              reg_wen_w_q,   reg_wen_w_d;
  logic [REG_AW-1:0] reg_waddr_w_q, reg_waddr_w_d;
  logic              st_en_w_q,     st_en_w_d;
  logic [MEM_AW-1:0] st_addr_w_q,   st_addr_w_d;
  logic              carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;

  logic              stall_s, accept_s, rf_we_s, op2_reg_s;
  logic [DATA_W-1:0] wb_data_s, op1_s, op2_s, rreg2_s, res_s;
  logic [DATA_W:0]   ext_s;
  logic              c_new_s, c_upd_s, fl_upd_s, wr_ok_s;

  assign stall_s   = w_valid_q && st_en_w_q && !mem_ready;
  assign op2_reg_s = !op2_mem_sel && !op2_imm_sel;
  assign rf_we_s   = w_valid_q && reg_wen_w_q && !stall_s;

`ifdef EXEC_FWD_EN
  logic hit1_s, hit2_s;
  assign hit1_s   = w_valid_q && reg_wen_w_q && (reg_waddr_w_q == raddr1);
  assign hit2_s   = w_valid_q && reg_wen_w_q && (reg_waddr_w_q == raddr2);
  assign op1_s    = hit1_s ? wb_data_s : rf_q[raddr1];
  assign rreg2_s  = hit2_s ? wb_data_s : rf_q[raddr2];
  assign in_ready = !stall_s;
`else
  logic hazard_s;
  assign hazard_s = w_valid_q && reg_wen_w_q &&
                    ((reg_waddr_w_q == raddr1) || (op2_reg_s && (reg_waddr_w_q == raddr2)));
  assign op1_s    = rf_q[raddr1];
  assign rreg2_s  = rf_q[raddr2];
  assign in_ready = !stall_s && !hazard_s;
`endif

  assign op2_s    = op2_mem_sel ? mem_rdata : (op2_imm_sel ? op2_imm : rreg2_s);
  assign accept_s = in_valid && in_ready;
  assign eq_flag  = in_valid && (op1_s == op2_s);

  assign mem_we    = w_valid_q && st_en_w_q;
  assign mem_waddr = st_addr_w_q;
  assign mem_wdata = wb_data_s;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

  // Write-back extension of the W-stage result.
  always_comb begin
    wb_data_s = result_w_q;
    case (wb_mode_w_q)
      2'd1: begin
        wb_data_s      = {DATA_W{result_w_q[7]}};
        wb_data_s[7:0] = result_w_q[7:0];
      end
      2'd2: begin
        wb_data_s      = '0;
        wb_data_s[7:0] = result_w_q[7:0];
      end
      default: wb_data_s = result_w_q;
    endcase
  end

  // ALU: result, carry/borrow and which side effects the opcode permits.
  always_comb begin
    ext_s    = '0;
    res_s    = '0;
    c_new_s  = 1'b0;
    c_upd_s  = 1'b0;
    fl_upd_s = 1'b1;
    wr_ok_s  = 1'b1;
    case (alu_opcode)
      OP_ADD: begin
        ext_s = {1'b0, op1_s} + {1'b0, op2_s};
        res_s = ext_s[DATA_W-1:0]; c_new_s = ext_s[DATA_W]; c_upd_s = 1'b1;
      end
      OP_ADC: begin
        ext_s = {1'b0, op1_s} + {1'b0, op2_s} + {{DATA_W{1'b0}}, carry_q};
        res_s = ext_s[DATA_W-1:0]; c_new_s = ext_s[DATA_W]; c_upd_s = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        ext_s   = {1'b0, op1_s} - {1'b0, op2_s};
        res_s   = ext_s[DATA_W-1:0]; c_new_s = ext_s[DATA_W]; c_upd_s = 1'b1;
        wr_ok_s = (alu_opcode != OP_CMP);
      end
      OP_SBB: begin
        ext_s = {1'b0, op1_s} - {1'b0, op2_s} - {{DATA_W{1'b0}}, carry_q};
        res_s = ext_s[DATA_W-1:0]; c_new_s = ext_s[DATA_W]; c_upd_s = 1'b1;
      end
      OP_AND:  res_s = op1_s & op2_s;
      OP_OR:   res_s = op1_s | op2_s;
      OP_XOR:  res_s = op1_s ^ op2_s;
      OP_NOT:  res_s = ~op1_s;
      OP_PASS: res_s = op2_s;
      OP_SHL: begin
        res_s = {op1_s[DATA_W-2:0], 1'b0}; c_new_s = op1_s[DATA_W-1]; c_upd_s = 1'b1;
      end
      OP_SHR: begin
        res_s = {1'b0, op1_s[DATA_W-1:1]}; c_new_s = op1_s[0]; c_upd_s = 1'b1;
      end
      default: begin
        res_s    = '0;
        fl_upd_s = 1'b0;
        wr_ok_s  = 1'b0;
      end
    endcase
  end

  // Flag next-state; updated in the accept cycle so the following ADC/SBB sees it.
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (accept_s && update_flags && fl_upd_s) begin
      zero_d = (res_s == '0);
      neg_d  = res_s[DATA_W-1];
      if (c_upd_s) begin
        carry_d = c_new_s;
      end else begin
        carry_d = carry_q;
      end
    end else begin
      carry_d = carry_q;
    end
  end

  // W-stage next-state: hold on a store stall, otherwise advance.
  always_comb begin
    w_valid_d     = w_valid_q;
    result_w_d    = result_w_q;
    wb_mode_w_d   = wb_mode_w_q;
    reg_wen_w_d   = reg_wen_w_q;
    reg_waddr_w_d = reg_waddr_w_q;
    st_en_w_d     = st_en_w_q;
    st_addr_w_d   = st_addr_w_q;
    if (stall_s) begin
      w_valid_d = w_valid_q;
    end else if (accept_s) begin
      w_valid_d     = 1'b1;
      result_w_d    = res_s;
      wb_mode_w_d   = wb_mode;
      reg_wen_w_d   = reg_wen && wr_ok_s;
      reg_waddr_w_d = reg_waddr;
      st_en_w_d     = st_en && wr_ok_s;
      st_addr_w_d   = st_addr;
    end else begin
      w_valid_d = 1'b0;
    end
  end

  // Register file next-state; the write retires together with any pending store.
  always_comb begin
    rf_d = rf_q;
    if (rf_we_s) begin
      rf_d[reg_waddr_w_q] = wb_data_s;
    end else begin
      rf_d = rf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
      w_valid_q     <= 1'b0;
      result_w_q    <= '0;
      wb_mode_w_q   <= 2'd0;
      reg_wen_w_q   <= 1'b0;
      reg_waddr_w_q <= '0;
      st_en_w_q     <= 1'b0;
      st_addr_w_q   <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      neg_q         <= 1'b0;
    end else begin
      rf_q          <= rf_d;
      w_valid_q     <= w_valid_d;
      result_w_q    <= result_w_d;
      wb_mode_w_q   <= wb_mode_w_d;
      reg_wen_w_q   <= reg_wen_w_d;
      reg_waddr_w_q <= reg_waddr_w_d;
      st_en_w_q     <= st_en_w_d;
      st_addr_w_q   <= st_addr_w_d;
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      neg_q         <= neg_d;
    end
  end

endmodule
